// File: rtl/id_stage_if.sv
// id_stage_if: ID/EX operand bundle; master (ID) drives OutValid/InsOut/Rdata1/Rdata2/Ed32/nextPC, slave (EX) reads them
interface id_stage_if;
  logic        OutValid;
  logic [31:0] InsOut;
  logic [31:0] Rdata1;
  logic [31:0] Rdata2;
  logic [31:0] Ed32;
  logic [31:0] nextPC;
  modport master (output OutValid, InsOut, Rdata1, Rdata2, Ed32, nextPC);
  modport slave  (input  OutValid, InsOut, Rdata1, Rdata2, Ed32, nextPC);
endinterface

// File: rtl/id_stage.sv
// id_stage: MIPS decode with 32x32 GPR file; inputs CLK/RST, IF (InsValid/Ins/nextPCIn), hazard (Stall/Flush), WB (WE/Waddr/Wdata); outputs via id_stage_if.master ex
module id_stage #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        InsValid,
  input  logic [31:0] Ins,
  input  logic [31:0] nextPCIn,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        WE,
  input  logic [4:0]  Waddr,
  input  logic [31:0] Wdata,
  id_stage_if.master  ex
);
  logic [31:0] gpr_q [32];
  logic        valid_q, valid_d;
  logic [31:0] ins_q, ins_d, rd1_q, rd1_d, rd2_q, rd2_d, ed_q, ed_d, pc_q, pc_d;
  logic [4:0]  rs, rt;
  logic [5:0]  op;
  logic [15:0] imm;
  logic [31:0] rd1, rd2, ed;
  logic        wr, hold, cap;
  assign rs  = Ins[25:21];
  assign rt  = Ins[20:16];
  assign op  = Ins[31:26];
  assign imm = Ins[15:0];
  assign wr  = WE && Waddr != 5'd0;
  always_ff @(posedge CLK or posedge RST)
    if (RST) for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
    else if (wr) gpr_q[Waddr] <= Wdata;
  always_comb begin
    rd1  = (BYPASS && wr && Waddr == rs) ? Wdata : gpr_q[rs];
    rd2  = (BYPASS && wr && Waddr == rt) ? Wdata : gpr_q[rt];
    ed   = op == 6'h0F ? {imm, 16'h0} :
           (op == 6'h0C || op == 6'h0D || op == 6'h0E) ? {16'h0, imm} : {{16{imm[15]}}, imm};
    hold = Stall && !Flush;
    cap  = !Flush && !Stall && InsValid;
    valid_d = hold ? valid_q : cap;
    ins_d   = hold ? ins_q : cap ? Ins : '0;
    rd1_d   = hold ? rd1_q : cap ? rd1 : '0;
    rd2_d   = hold ? rd2_q : cap ? rd2 : '0;
    ed_d    = hold ? ed_q  : cap ? ed  : '0;
    pc_d    = hold ? pc_q  : cap ? nextPCIn : '0;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      valid_q <= 1'b0;
      ins_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      ed_q    <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ins_q   <= ins_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      ed_q    <= ed_d;
      pc_q    <= pc_d;
    end
  assign ex.OutValid = valid_q;
  assign ex.InsOut   = ins_q;
  assign ex.Rdata1   = rd1_q;
  assign ex.Rdata2   = rd2_q;
  assign ex.Ed32     = ed_q;
  assign ex.nextPC   = pc_q;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed checks of id_stage with BYPASS=1 (b) and BYPASS=0 (n) sharing one stimulus
module tb_id_stage;
  logic        CLK = 1'b0, RST = 1'b1, InsValid = 1'b0, Stall = 1'b0, Flush = 1'b0, WE = 1'b0;
  logic [31:0] Ins = '0, nextPCIn = '0, Wdata = '0;
  logic [4:0]  Waddr = '0;
  int          passed = 0, failed = 0, total = 0;
  id_stage_if  eb ();
  id_stage_if  en ();
  id_stage #(.BYPASS(1'b1)) dut_b (.CLK(CLK), .RST(RST), .InsValid(InsValid), .Ins(Ins), .nextPCIn(nextPCIn),
    .Stall(Stall), .Flush(Flush), .WE(WE), .Waddr(Waddr), .Wdata(Wdata), .ex(eb.master));
  id_stage #(.BYPASS(1'b0)) dut_n (.CLK(CLK), .RST(RST), .InsValid(InsValid), .Ins(Ins), .nextPCIn(nextPCIn),
    .Stall(Stall), .Flush(Flush), .WE(WE), .Waddr(Waddr), .Wdata(Wdata), .ex(en.master));
  always #5 CLK = ~CLK;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [31:0] v, ins, r1, r2, e, pc);
    chk({tag, ".valid"}, {31'd0, eb.OutValid}, v);
    chk({tag, ".ins"}, eb.InsOut, ins);
    chk({tag, ".rd1"}, eb.Rdata1, r1);
    chk({tag, ".rd2"}, eb.Rdata2, r2);
    chk({tag, ".ed32"}, eb.Ed32, e);
    chk({tag, ".pc"}, eb.nextPC, pc);
  endtask
  initial begin
    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    RST = 1'b0;
    tick;
    WE = 1; Waddr = 5'd5; Wdata = 32'h5;
    tick;
    Waddr = 5'd6; Wdata = 32'h3;
    tick;
    WE = 0; InsValid = 1; Ins = 32'h00A62020; nextPCIn = 32'h104;
    tick;
    chk_all("add", 1, 32'h00A62020, 32'h5, 32'h3, 32'h2020, 32'h104);
    chk("add.n.rd1", en.Rdata1, 32'h5);
    chk("add.n.rd2", en.Rdata2, 32'h3);
    WE = 1; Waddr = 5'd0; Wdata = 32'hFFFFFFFF; Ins = 32'h00002020;
    tick;
    chk("r0.byp", eb.Rdata1, 32'h0);
    WE = 0;
    tick;
    chk("r0.rd1", eb.Rdata1, 32'h0);
    chk("r0.rd2", eb.Rdata2, 32'h0);
    chk("r0.n.rd1", en.Rdata1, 32'h0);
    WE = 1; Waddr = 5'd5; Wdata = 32'h1234; Ins = 32'h00A62020;
    tick;
    chk("byp.b.rd1", eb.Rdata1, 32'h1234);
    chk("byp.n.rd1", en.Rdata1, 32'h5);
    chk("byp.b.rd2", eb.Rdata2, 32'h3);
    WE = 0;
    tick;
    chk("after.n.rd1", en.Rdata1, 32'h1234);
    Ins = 32'h2000FFFE; tick; chk("addi.ed", eb.Ed32, 32'hFFFFFFFE);
    Ins = 32'h3000FFFE; tick; chk("andi.ed", eb.Ed32, 32'h0000FFFE);
    Ins = 32'h3400FFFE; tick; chk("ori.ed", eb.Ed32, 32'h0000FFFE);
    Ins = 32'h3800FFFE; tick; chk("xori.ed", eb.Ed32, 32'h0000FFFE);
    Ins = 32'h3C001234; tick; chk("lui.ed", eb.Ed32, 32'h12340000);
    Ins = 32'h24008000; tick; chk("addiu.ed", eb.Ed32, 32'hFFFF8000);
    Ins = 32'h00A62020; nextPCIn = 32'h200;
    tick;
    chk_all("cap", 1, 32'h00A62020, 32'h1234, 32'h3, 32'h2020, 32'h200);
    Stall = 1; Ins = 32'h2000FFFE; nextPCIn = 32'h204; WE = 1; Waddr = 5'd6; Wdata = 32'h77;
    for (int i = 0; i < 3; i++) begin
      tick;
      WE = 0;
      chk_all("stall", 1, 32'h00A62020, 32'h1234, 32'h3, 32'h2020, 32'h200);
    end
    Flush = 1;
    tick;
    chk("flush.valid", {31'd0, eb.OutValid}, 0);
    chk("flush.ins", eb.InsOut, 0);
    Flush = 0; Stall = 0; Ins = 32'h00A62020;
    tick;
    chk("post.rd2", eb.Rdata2, 32'h77);
    InsValid = 0; Ins = 32'h00000020; nextPCIn = 32'h8;
    tick;
    chk("bubble.valid", {31'd0, eb.OutValid}, 0);
    chk("bubble.ins", eb.InsOut, 0);
    InsValid = 1; Ins = 32'h00A62020; nextPCIn = 32'h300;
    tick;
    chk("pre.valid", {31'd0, eb.OutValid}, 1);
    #2 RST = 1;
    #1;
    chk_all("midrst", 0, 0, 0, 0, 0, 0);
    chk("midrst.n.valid", {31'd0, en.OutValid}, 0);
    tick;
    RST = 0;
    for (int i = 1; i < 32; i++) begin
      Ins = {6'd0, i[4:0], i[4:0], 16'h0};
      tick;
      chk($sformatf("clr.r%0d", i), eb.Rdata1 | eb.Rdata2 | en.Rdata1, 32'h0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- MIPS instruction-decode stage: the producer side of the EX stage's operand interface.
- Holds the 32x32 general-purpose register file, written from writeback.
- Decodes rs/rt and the 16-bit immediate, then presents Ins, Rdata1, Rdata2, Ed32 and nextPC to EX through a registered ID/EX pipeline boundary.
- Supports stall and flush from hazard/branch control.

Parameters:
BYPASS, 1, 1 = same-cycle writeback-to-read forwarding inside the register file; 0 = read returns the pre-write value.

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  asynchronous active-high reset
InsValid  in  1  Ins/nextPCIn carry a valid instruction this cycle
Ins  in  32  instruction word from IF
nextPCIn  in  32  PC+4 from IF
Stall  in  1  hold ID/EX register contents
Flush  in  1  insert bubble into ID/EX register
WE  in  1  register file write enable from WB
Waddr  in  5  register file write address
Wdata  in  32  register file write data
OutValid  out  1  ID/EX entry valid
InsOut  out  32  registered instruction to EX (EX Ins)
Rdata1  out  32  registered GPR[rs]
Rdata2  out  32  registered GPR[rt]
Ed32  out  32  registered extended immediate
nextPC  out  32  registered PC+4

Behaviour:
- Reset (async, RST=1):
  - All 32 GPRs = 0.
  - OutValid=0; InsOut, Rdata1, Rdata2, Ed32, nextPC = 0.
  - Release is synchronous to the next CLK edge; no write or capture occurs while RST=1.
- Register file:
  - rs=Ins[25:21], rt=Ins[20:16].
  - Write at posedge when WE=1 and Waddr!=0.
  - GPR0 always reads 0; writes to it are discarded.
  - Reads are combinational from the array.
  - If BYPASS=1, WE=1, Waddr!=0 and Waddr equals the read address, the read returns Wdata in the same cycle.
- Immediate extension (Ed32), opcode=Ins[31:26]:
  - 0x0C/0x0D/0x0E (ANDI/ORI/XORI): zero-extend Ins[15:0].
  - 0x0F (LUI): {Ins[15:0],16'h0}.
  - All other opcodes: sign-extend Ins[15:0].
- ID/EX register, evaluated at each posedge in priority order:
  1. Flush=1: OutValid=0 and InsOut=0 (NOP); other data outputs may be 0. Flush overrides Stall.
  2. Stall=1: all outputs hold.
  3. Otherwise: capture OutValid=InsValid, InsOut=Ins, Rdata1/Rdata2 (with bypass), Ed32, nextPC=nextPCIn.
- When InsValid=0 and neither Flush nor Stall: OutValid=0 and InsOut=0; other fields don't-care (drive 0).
- Latency: one cycle from Ins to outputs.
- Register writes proceed regardless of Stall/Flush.
- Simultaneous write and read of the same register in the capture cycle:
  - BYPASS=1: new value.
  - BYPASS=0: old value.
- Stall held for N cycles: while stalled, outputs are not refreshed with later register writes; the held snapshot stays.
- Reset mid-operation: immediate clear per the reset list above; no partial write survives.

Test Plan:
- Reset: assert RST mid-stream with OutValid=1 -> all outputs 0 immediately (before the next edge); after release, reading r1..r31 yields 0.
- Write/read: WE=1, Waddr=5, Wdata=0x00000005; next cycle Ins=0x00A62020 (add r4,r5,r6), r6 preloaded to 0x00000003 -> one cycle later Rdata1=0x5, Rdata2=0x3, InsOut=0x00A62020, OutValid=1.
- GPR0 and bypass:
  - WE=1, Waddr=0, Wdata=0xFFFFFFFF -> reading r0 gives 0.
  - Same-cycle WE=1, Waddr=5, Wdata=0x1234 with Ins reading rs=5 -> Rdata1=0x1234 (BYPASS=1); Rdata1 = old value with BYPASS=0.
- Extension:
  - Ins=0x2000FFFE (ADDI) -> Ed32=0xFFFFFFFE.
  - Ins=0x3000FFFE (ANDI) -> Ed32=0x0000FFFE.
  - Ins=0x3C001234 (LUI) -> Ed32=0x12340000.
- Stall/flush:
  - Capture ADD, then Stall=1 for 3 cycles while Ins changes -> outputs unchanged.
  - Then Flush=1 together with Stall=1 -> OutValid=0, InsOut=0 next edge.
- Bubble: InsValid=0 with Ins=0x00000020 -> OutValid=0, InsOut=0 next edge; nextPCIn=0x8 is not required on nextPC.
